// File: rtl/obf_pkg.sv
// obf_pkg: shared state type, select patterns and LFSR step for obf_key_sched
package obf_pkg;
  typedef enum logic [1:0] {LOCKED, CHECK, UNLOCKED, LOCKOUT} state_t;
  localparam logic SEL_FUNC_S1 = 1'b1;
  localparam logic SEL_FUNC_S2 = 1'b0;
  localparam logic SEL_LOCK_S1 = 1'b0;
  localparam logic SEL_LOCK_S2 = 1'b1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/obf_key_sched_if.sv
// obf_key_sched_if: valid/ready key handshake between a key source and obf_key_sched
//   key_valid/key_in : driven by master, key_ready : driven by slave
interface obf_key_sched_if #(
  parameter int KEY_W = 16
);
  logic             key_valid;
  logic [KEY_W-1:0] key_in;
  logic             key_ready;
  modport master (output key_valid, key_in, input key_ready);
  modport slave (input key_valid, key_in, output key_ready);
endinterface

// File: rtl/obf_lfsr16.sv
// obf_lfsr16: free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1
//   clk, rst_n (async, active-low), seed (reset value, 0 maps to 1), state (current value)
module obf_lfsr16
  import obf_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] state
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= seed == 16'h0000 ? 16'h0001 : seed;
    else state <= lfsr_next(state);
endmodule

// File: rtl/obf_key_sched.sv
// obf_key_sched: key-gated select/random controller for the obfuscated c17 core
//   clk, rst_n (async, active-low)
//   bus       : key handshake (key_valid, key_in in; key_ready out)
//   sel1/sel2/rnd : drive s1/s2/random of the obfuscated core
//   unlocked  : functional pattern active, lockout : sticky after MAX_TRIES wrong keys
//   tries     : consecutive failed attempts
//   OBF_SCRAMBLE_EN : when defined, the locked pattern is re-drawn from an LFSR
//                     every SCRAMBLE_DIV cycles instead of staying static
module obf_key_sched
  import obf_pkg::*;
#(
  parameter int               KEY_W         = 16,
  parameter logic [KEY_W-1:0] KEY_VAL       = KEY_W'(16'hA5C3),
  parameter int               RELOCK_CYCLES = 1024,
  parameter int               MAX_TRIES     = 3,
  parameter int               SCRAMBLE_DIV  = 4,
  parameter logic [15:0]      LFSR_SEED     = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  obf_key_sched_if.slave                 bus,
  output logic                           sel1,
  output logic                           sel2,
  output logic                           rnd,
  output logic                           unlocked,
  output logic                           lockout,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int TMW = $clog2(RELOCK_CYCLES + 1);
  if (RELOCK_CYCLES < 2 || MAX_TRIES < 1 || SCRAMBLE_DIV < 1) begin : g_bad_params
    $error("obf_key_sched: RELOCK_CYCLES>=2, MAX_TRIES>=1, SCRAMBLE_DIV>=1 required");
  end
  state_t state, nxt;
  logic [TMW-1:0] timer;
  logic key_ok, hs, last_try, lk_s1, lk_s2, lk_r;
  // the last window cycle refuses keys so expiry always wins over a late key
  assign bus.key_ready = state == LOCKED || (state == UNLOCKED && timer != TMW'(1));
  assign hs = bus.key_valid && bus.key_ready;
  assign last_try = tries == TW'(MAX_TRIES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOCKED;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      LOCKED:   nxt = bus.key_valid ? CHECK : LOCKED;
      CHECK:    nxt = key_ok ? UNLOCKED : last_try ? LOCKOUT : LOCKED;
      UNLOCKED: nxt = hs ? CHECK : timer == TMW'(1) ? LOCKED : UNLOCKED;
      default:  nxt = LOCKOUT;
    endcase
  end
`ifdef OBF_SCRAMBLE_EN
  localparam int DW = $clog2(SCRAMBLE_DIV + 1);
  logic [15:0] lfsr;
  logic [DW-1:0] div;
  logic wrap, stay;
  obf_lfsr16 u_lfsr (.clk(clk), .rst_n(rst_n), .seed(LFSR_SEED), .state(lfsr));
  assign wrap = div == DW'(SCRAMBLE_DIV - 1);
  // entering a locked state shows the static pattern; only staying there re-draws it
  assign stay = nxt == state && (state == LOCKED || state == LOCKOUT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div <= '0;
    else div <= wrap ? '0 : div + 1'b1;
  // OR-ing lfsr[0] into sel2 keeps (1,0), the functional pattern, from ever appearing
  always_comb begin
    lk_s1 = SEL_LOCK_S1;
    lk_s2 = SEL_LOCK_S2;
    lk_r = 1'b0;
    if (stay) begin
      lk_s1 = wrap ? lfsr[0] : sel1;
      lk_s2 = wrap ? lfsr[5] | lfsr[0] : sel2;
      lk_r = wrap ? lfsr[10] : rnd;
    end
  end
`else
  assign lk_s1 = SEL_LOCK_S1;
  assign lk_s2 = SEL_LOCK_S2;
  assign lk_r = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer <= '0;
      tries <= '0;
      key_ok <= 1'b0;
      sel1 <= SEL_LOCK_S1;
      sel2 <= SEL_LOCK_S2;
      rnd <= 1'b0;
      unlocked <= 1'b0;
      lockout <= 1'b0;
    end else begin
      if (hs) key_ok <= bus.key_in == KEY_VAL;
      if (state == CHECK) begin
        tries <= key_ok ? '0 : tries == TW'(MAX_TRIES) ? tries : tries + 1'b1;
        if (key_ok) timer <= TMW'(RELOCK_CYCLES);
      end else if (state == UNLOCKED) timer <= timer - 1'b1;
      sel1 <= nxt == UNLOCKED ? SEL_FUNC_S1 : nxt == CHECK ? sel1 : lk_s1;
      sel2 <= nxt == UNLOCKED ? SEL_FUNC_S2 : nxt == CHECK ? sel2 : lk_s2;
      rnd <= nxt == UNLOCKED ? 1'b1 : nxt == CHECK ? rnd : lk_r;
      unlocked <= nxt == UNLOCKED ? 1'b1 : nxt == CHECK ? unlocked : 1'b0;
      lockout <= nxt == LOCKOUT;
    end
endmodule

// File: tb/tb_obf_key_sched.sv
// tb_obf_key_sched: directed plus random key traffic against a window/try-count reference model
module tb_obf_key_sched;
  localparam logic [15:0] KEY = 16'hA5C3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int R = 1024;
  localparam int MAX = 3;
  localparam int DIV = 4;
`ifdef OBF_SCRAMBLE_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sel1, sel2, rnd, unlocked, lockout;
  logic [1:0] tries;
  obf_key_sched_if #(.KEY_W(16)) bus ();
  obf_key_sched dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sel1(sel1), .sel2(sel2), .rnd(rnd),
    .unlocked(unlocked), .lockout(lockout), .tries(tries)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int win, pend, m_tries, n, cnt;
  bit lock;
  logic [15:0] lf;
  logic e1, e2, er;
  function automatic logic [15:0] poly_step(input logic [15:0] s);
    return s[0] ? (s >> 1) ^ 16'hB400 : s >> 1;
  endfunction
  function automatic logic [15:0] wrong_key();
    logic [15:0] k;
    k = 16'($urandom);
    return k == KEY ? k ^ 16'h0001 : k;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cmp_all(input string tag);
    chk({tag, "_unl"}, 32'(unlocked), 32'(win > 0));
    chk({tag, "_s1"}, 32'(sel1), 32'(e1));
    chk({tag, "_s2"}, 32'(sel2), 32'(e2));
    chk({tag, "_rnd"}, 32'(rnd), 32'(er));
    chk({tag, "_lko"}, 32'(lockout), 32'(lock));
    chk({tag, "_tries"}, 32'(tries), 32'(m_tries));
    chk({tag, "_rdy"}, 32'(bus.key_ready), 32'(!lock && pend < 0 && win != 1));
  endtask
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    win = 0; pend = -1; m_tries = 0; lock = 1'b0; n = 0; lf = SEED;
    {e1, e2, er} = 3'b010;
    cmp_all(tag);
    #2 rst_n = 1'b1;
  endtask
  task automatic cyc(input bit v, input logic [15:0] k, input string tag);
    bit rdy, wrap, stay;
    logic [15:0] lo;
    rdy = !lock && pend < 0 && win != 1;
    bus.key_valid = v;
    bus.key_in = k;
    @(posedge clk);
    n++;
    wrap = n % DIV == 0;
    lo = lf;
    lf = poly_step(lf);
    stay = lock || (pend < 0 && !(v && rdy) && win == 0);
    if (stay) begin
      if (SCR && wrap) {e1, e2, er} = {lo[0], lo[5] | lo[0], lo[10]};
    end else if (pend >= 0) begin
      if (pend == 1) begin
        win = R; m_tries = 0; {e1, e2, er} = 3'b101;
      end else begin
        m_tries++; win = 0; lock = m_tries == MAX; {e1, e2, er} = 3'b010;
      end
      pend = -1;
    end else if (v && rdy) pend = k == KEY ? 1 : 0;
    else begin
      win--;
      if (win == 0) {e1, e2, er} = 3'b010;
    end
    #1 cmp_all(tag);
  endtask
  initial begin
    bit seen[4];
    bit seen_r[2];
    int bad;
    logic [1:0] prev;
    bus.key_valid = 1'b0;
    bus.key_in = '0;
    @(posedge clk);
    #1 do_reset("rst0");
    cyc(1'b1, KEY, "t1_hs");
    cyc(1'b0, 16'h0, "t1_chk");
    cnt = 0;
    while (unlocked === 1'b1 && cnt < 2000) begin
      cnt++;
      cyc(1'b0, 16'h0, "t1_win");
    end
    chk("t1_len", 32'(cnt), 32'(R));
    chk("t1_relock_s2", 32'(sel2), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h0000, "t2_key");
      cyc(1'b0, 16'h0, "t2_chk");
      chk("t2_tries", 32'(tries), 32'(i + 1));
    end
    chk("t2_lockout", 32'(lockout), 32'd1);
    chk("t2_rdy", 32'(bus.key_ready), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, KEY, "t2_ign");
    chk("t2_ign_unl", 32'(unlocked), 32'd0);
    do_reset("t2_rst");
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, wrong_key(), "t3_bad");
      cyc(1'b0, 16'h0, "t3_bchk");
    end
    cyc(1'b1, KEY, "t3_good");
    cyc(1'b0, 16'h0, "t3_gchk");
    chk("t3_unl", 32'(unlocked), 32'd1);
    chk("t3_tries0", 32'(tries), 32'd0);
    for (int i = 0; i < 2; i++) begin
      repeat (5) cyc(1'b0, 16'h0, "t3_idle");
      cyc(1'b1, wrong_key(), "t3_wbad");
      cyc(1'b0, 16'h0, "t3_wchk");
      cyc(1'b1, KEY, "t3_re");
      cyc(1'b0, 16'h0, "t3_rechk");
    end
    chk("t3_nolock", 32'(lockout), 32'd0);
    do_reset("t4_rst");
    cyc(1'b1, KEY, "t4_hs");
    cyc(1'b0, 16'h0, "t4_chk");
    while (win != 500) cyc(1'b0, 16'h0, "t4_run");
    cyc(1'b1, KEY, "t4_ref");
    chk("t4_hold", 32'(unlocked), 32'd1);
    cyc(1'b0, 16'h0, "t4_rchk");
    cnt = 0;
    while (unlocked === 1'b1 && cnt < 2000) begin
      cnt++;
      cyc(1'b0, 16'h0, "t4_win");
    end
    chk("t4_len", 32'(cnt), 32'(R));
    cyc(1'b1, KEY, "t4_hs2");
    cyc(1'b0, 16'h0, "t4_chk2");
    while (win > 1) cyc(1'b0, 16'h0, "t4_run2");
    chk("t4_rdy1", 32'(bus.key_ready), 32'd0);
    cyc(1'b1, KEY, "t4_exp");
    chk("t4_exp_unl", 32'(unlocked), 32'd0);
    repeat (2) cyc(1'b0, 16'h0, "t4_after");
    cyc(1'b1, KEY, "t6_hs");
    do_reset("t6_rst_chk");
    cyc(1'b1, KEY, "t6_hs2");
    cyc(1'b0, 16'h0, "t6_chk2");
    repeat (10) cyc(1'b0, 16'h0, "t6_unl");
    do_reset("t6_rst_unl");
    for (int i = 0; i < 3000; i++) begin
      if (lock && $urandom_range(0, 15) == 0) do_reset("rnd_rst");
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1 ? KEY : wrong_key(), "rnd");
    end
    do_reset("t5_rst");
    bad = 0;
    prev = {sel1, sel2};
    for (int i = 0; i < 4000; i++) begin
      cyc(1'b0, 16'h0, "t5");
      if ({sel1, sel2} != prev && n % DIV != 0) bad++;
      prev = {sel1, sel2};
      seen[{sel1, sel2}] = 1'b1;
      seen_r[rnd] = 1'b1;
    end
    chk("t5_onwrap", 32'(bad), 32'd0);
    chk("t5_no10", 32'(seen[2]), 32'd0);
    chk("t5_01", 32'(seen[1]), 32'd1);
    chk("t5_00", 32'(seen[0]), 32'(SCR));
    chk("t5_11", 32'(seen[3]), 32'(SCR));
    chk("t5_r0", 32'(seen_r[0]), 32'd1);
    chk("t5_r1", 32'(seen_r[1]), 32'(SCR));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
